// File: rtl/phy_rx_deserializer.sv
`default_nettype none

// ============================================================================
//  Module   : phy_rx_lane
//  Purpose  : One receive lane of the two-lane serial PHY. Shifts in one bit
//             per clock (MSB first), hunts for the comma byte, confirms byte
//             alignment over several consecutive commas and then, once the
//             link is enabled, pairs data bytes into half-words.
//  Ports    : clk_32f      - bit clock, all logic on the rising edge
//             reset        - synchronous active-high reset
//             din          - serial input bit
//             enable       - link-wide ACTIVE flag (registered, from top)
//             lane_active  - this lane has reached ACTIVE
//             half_done    - a {hi, lo} half-word completes this cycle
//             frame_err    - a pending high byte is cut short by a comma
//             hi_byte      - latched high byte of the half-word
//             lo_byte      - low byte (the byte completing this cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module phy_rx_lane #(
    parameter logic [7:0] COM_BYTE   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       din,
    input  logic       enable,
    output logic       lane_active,
    output logic       half_done,
    output logic       frame_err,
    output logic [7:0] hi_byte,
    output logic [7:0] lo_byte
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] C_SYNC = 4'(SYNC_COUNT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    // Only the seven most recent bits are needed: together with the
    // incoming bit they form the candidate byte.
    logic [6:0] r_sr;
    logic [7:0] w_nxt;
    logic [2:0] r_bitcnt;
    logic [3:0] r_comcnt;
    logic [7:0] r_hi;
    logic       r_pending;

    logic       w_is_com;
    logic       w_boundary;
    logic       w_active_boundary;

    assign w_nxt      = {r_sr, din};
    assign w_is_com   = (w_nxt == COM_BYTE);
    assign w_boundary = (r_bitcnt == 3'd7);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_com) begin
                    w_state_nxt = (C_SYNC == 4'd1) ? ST_ACTIVE : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (!w_is_com) begin
                        w_state_nxt = ST_SEARCH;
                    end else if ((r_comcnt + 4'd1) == C_SYNC) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                // No loss-of-sync detection: only reset leaves ACTIVE.
                w_state_nxt = ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        lane_active       = (r_state == ST_ACTIVE);
        // Bytes are only interpreted once the whole link is up.
        w_active_boundary = lane_active && enable && w_boundary;
        half_done         = w_active_boundary && !w_is_com && r_pending;
        frame_err         = w_active_boundary &&  w_is_com && r_pending;
        hi_byte           = r_hi;
        lo_byte           = w_nxt;
    end

    // ------------------------------------------------------------------
    // Shifter, bit/comma counters and half-word latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr      <= '0;
            r_bitcnt  <= '0;
            r_comcnt  <= '0;
            r_hi      <= '0;
            r_pending <= 1'b0;
        end else begin
            r_sr     <= w_nxt[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            case (r_state)
                ST_SEARCH: begin
                    if (w_is_com) begin
                        // The comma just completed, so the next bit starts
                        // a fresh byte.
                        r_bitcnt <= 3'd0;
                        r_comcnt <= 4'd1;
                    end
                end
                ST_ALIGN: begin
                    if (w_boundary) begin
                        r_comcnt <= w_is_com ? (r_comcnt + 4'd1) : 4'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_active_boundary) begin
                        if (w_is_com) begin
                            r_pending <= 1'b0;
                        end else if (!r_pending) begin
                            r_hi      <= w_nxt;
                            r_pending <= 1'b1;
                        end else begin
                            r_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_comcnt <= '0;
                end
            endcase
        end
    end

endmodule

// ============================================================================
//  Module   : phy_rx_deserializer
//  Purpose  : Receive side of the two-lane serial PHY. Aligns both lanes on
//             the comma byte, declares the link active and reassembles 32-bit
//             words. Lane 0 carries word[31:24] then word[15:8]; lane 1
//             carries word[23:16] then word[7:0].
//  Ports    : clk_32f    - bit clock, all logic on the rising edge
//             reset      - synchronous active-high reset
//             data_in0   - serial lane 0
//             data_in1   - serial lane 1
//             data_out   - reassembled word, valid while valid_out=1
//             valid_out  - one-cycle strobe per received word
//             active_out - both lanes ACTIVE
//             err_out    - one-cycle strobe on framing or skew error
//  Revision : 1.0 - initial release
// ============================================================================
module phy_rx_deserializer #(
    parameter logic [7:0] COM_BYTE   = 8'hBC,
    parameter int         SYNC_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in0,
    input  logic        data_in1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_out,
    output logic        err_out
);

    logic       w_act0, w_act1;
    logic       w_hd0,  w_hd1;
    logic       w_fe0,  w_fe1;
    logic [7:0] w_hi0,  w_hi1;
    logic [7:0] w_lo0,  w_lo1;
    logic       w_word;
    logic       w_skew;

    phy_rx_lane #(
        .COM_BYTE   (COM_BYTE),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_lane0 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .din         (data_in0),
        .enable      (active_out),
        .lane_active (w_act0),
        .half_done   (w_hd0),
        .frame_err   (w_fe0),
        .hi_byte     (w_hi0),
        .lo_byte     (w_lo0)
    );

    phy_rx_lane #(
        .COM_BYTE   (COM_BYTE),
        .SYNC_COUNT (SYNC_COUNT)
    ) u_lane1 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .din         (data_in1),
        .enable      (active_out),
        .lane_active (w_act1),
        .half_done   (w_hd1),
        .frame_err   (w_fe1),
        .hi_byte     (w_hi1),
        .lo_byte     (w_lo1)
    );

    // A word is only good when both lanes finish their half-words on the
    // same boundary; a lone half-word means the lanes are skewed.
    assign w_word = w_hd0 & w_hd1;
    assign w_skew = w_hd0 ^ w_hd1;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            active_out <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            active_out <= w_act0 & w_act1;
            valid_out  <= w_word;
            // Framing and skew in the same cycle merge into one pulse.
            err_out    <= w_fe0 | w_fe1 | w_skew;
            if (w_word) begin
                data_out <= {w_hi0, w_hi1, w_lo0, w_lo1};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_rx_deserializer.sv
`default_nettype none

// ============================================================================
//  Module   : tb_phy_rx_deserializer
//  Purpose  : Directed + randomized bench for phy_rx_deserializer. Each phase
//             builds the two serial streams byte by byte, predicts the output
//             timeline from the byte list, then drives the bits and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_deserializer;

    localparam logic [7:0] COM  = 8'hBC;
    localparam int         SYNC = 4;
    localparam int         MAXC = 1024;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_in0;
    logic        data_in1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active_out;
    logic        err_out;

    phy_rx_deserializer #(
        .COM_BYTE   (COM),
        .SYNC_COUNT (SYNC)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .active_out (active_out),
        .err_out    (err_out)
    );

    always #5 clk_32f = ~clk_32f;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] v;
        int         e;   // cycle index of the byte's last bit
    } rec_t;

    bit   s0[$];
    bit   s1[$];
    rec_t r0[$];
    rec_t r1[$];

    logic [31:0] exp_data  [MAXC];
    bit          exp_valid [MAXC];
    bit          exp_err   [MAXC];
    bit          exp_act   [MAXC];
    bit          hd        [2][MAXC];
    bit          fe        [2][MAXC];
    logic [15:0] hw        [2][MAXC];

    task automatic chk(input string tag, input int cyc, input logic [34:0] obs, input logic [34:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic pad(input int lane, input int n);
        for (int i = 0; i < n; i++) begin
            if (lane == 0) s0.push_back(1'b0);
            else           s1.push_back(1'b0);
        end
    endtask

    task automatic put_byte(input int lane, input logic [7:0] b);
        rec_t r;
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) s0.push_back(b[i]);
            else           s1.push_back(b[i]);
        end
        r.v = b;
        if (lane == 0) begin r.e = s0.size() - 1; r0.push_back(r); end
        else           begin r.e = s1.size() - 1; r1.push_back(r); end
    endtask

    task automatic coms(input int n);
        for (int i = 0; i < n; i++) begin
            put_byte(0, COM);
            put_byte(1, COM);
        end
    endtask

    task automatic put_word(input logic [31:0] w);
        put_byte(0, w[31:24]);
        put_byte(0, w[15:8]);
        put_byte(1, w[23:16]);
        put_byte(1, w[7:0]);
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == COM);
        return b;
    endfunction

    function automatic logic [31:0] rnd_word();
        return {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
    endfunction

    // Cycle at which a lane has seen SYNC back-to-back commas, or -1.
    function automatic int find_sync(input int lane, input int len);
        rec_t q[$];
        int   run  = 0;
        int   prev = -100;
        if (lane == 0) q = r0; else q = r1;
        foreach (q[i]) begin
            if (q[i].e < len) begin
                if (q[i].v == COM) begin
                    if (run > 0 && q[i].e == prev + 8) run++;
                    else                              run = 1;
                end else begin
                    run = 0;
                end
                prev = q[i].e;
                if (run == SYNC) return q[i].e;
            end
        end
        return -1;
    endfunction

    task automatic build_model(input int len);
        int          a0, a1, ea;
        logic [31:0] cur;
        rec_t        q[$];
        bit          pend;
        logic [7:0]  hi;
        for (int k = 0; k < MAXC; k++) begin
            exp_valid[k] = 0; exp_err[k] = 0; exp_act[k] = 0;
            for (int l = 0; l < 2; l++) begin
                hd[l][k] = 0; fe[l][k] = 0; hw[l][k] = '0;
            end
        end
        a0 = find_sync(0, len);
        a1 = find_sync(1, len);
        if (a0 >= 0 && a1 >= 0) begin
            ea = (a0 > a1) ? a0 : a1;
            for (int k = ea + 1; k < len; k++) exp_act[k] = 1;
            // active_out is registered, so bytes count from ea+2 onward.
            for (int l = 0; l < 2; l++) begin
                if (l == 0) q = r0; else q = r1;
                pend = 0;
                hi   = '0;
                foreach (q[i]) begin
                    if (q[i].e >= ea + 2 && q[i].e < len) begin
                        if (q[i].v == COM) begin
                            if (pend) fe[l][q[i].e] = 1;
                            pend = 0;
                        end else if (!pend) begin
                            hi   = q[i].v;
                            pend = 1;
                        end else begin
                            hd[l][q[i].e] = 1;
                            hw[l][q[i].e] = {hi, q[i].v};
                            pend = 0;
                        end
                    end
                end
            end
        end
        cur = '0;
        for (int k = 0; k < len; k++) begin
            if (hd[0][k] && hd[1][k]) begin
                exp_valid[k] = 1;
                cur = {hw[0][k][15:8], hw[1][k][15:8], hw[0][k][7:0], hw[1][k][7:0]};
            end else if (hd[0][k] || hd[1][k]) begin
                exp_err[k] = 1;
            end
            if (fe[0][k] || fe[1][k]) exp_err[k] = 1;
            exp_data[k] = cur;
        end
    endtask

    // Reset for 3 cycles with random inputs, then play the streams.
    task automatic run_phase(input string name, input bit tail);
        int len;
        if (tail) coms(3);
        len = (s0.size() < s1.size()) ? s0.size() : s1.size();
        build_model(len);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in0 = 1'($urandom);
            data_in1 = 1'($urandom);
            @(posedge clk_32f);
            #1;
            chk({name, "_reset"}, i, {data_out, valid_out, active_out, err_out}, 35'd0);
        end
        reset = 1'b0;
        for (int k = 0; k < len; k++) begin
            data_in0 = s0[k];
            data_in1 = s1[k];
            @(posedge clk_32f);
            #1;
            chk({name, "_active"}, k, 35'(active_out), 35'(exp_act[k]));
            chk({name, "_valid"},  k, 35'(valid_out),  35'(exp_valid[k]));
            chk({name, "_err"},    k, 35'(err_out),    35'(exp_err[k]));
            chk({name, "_data"},   k, 35'(data_out),   35'(exp_data[k]));
        end
        s0.delete(); s1.delete(); r0.delete(); r1.delete();
    endtask

    initial begin
        reset    = 1'b1;
        data_in0 = 1'b0;
        data_in1 = 1'b0;

        // Sync with lane 1 three bits behind lane 0.
        pad(0, 4); pad(1, 7);
        coms(6);
        run_phase("sync_off3", 1'b1);

        // Lane 0 loses alignment on 0x55, resyncs; then the data bursts.
        pad(0, 8); pad(1, 8);
        for (int i = 0; i < 3; i++) put_byte(0, COM);
        put_byte(0, 8'h55);
        for (int i = 0; i < 4; i++) put_byte(0, COM);
        for (int i = 0; i < 8; i++) put_byte(1, COM);
        coms(1);
        put_word(32'hFFFF_FFFF);
        put_word(32'hEEEE_EEEE);
        put_word(32'hDDDD_DDDD);
        put_word(32'hCCCC_CCCC);
        coms(2);
        put_word(32'h0000_0003);
        put_word(32'h0000_0004);
        coms(1);
        for (int i = 0; i < 6; i++) begin
            put_word(rnd_word());
            coms($urandom_range(0, 2));
        end
        run_phase("data", 1'b1);

        // Framing error, then an intact word, then random traffic.
        begin
            int off;
            off = $urandom_range(0, 7);
            pad(0, off); pad(1, off);
        end
        coms(5);
        put_byte(0, 8'h12); put_byte(1, 8'h12);
        coms(1);
        put_word(32'hA1B2_C3D4);
        coms(1);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                put_byte(0, rnd_byte());
                put_byte(1, rnd_byte());
                coms(1);
            end else begin
                put_word(rnd_word());
                coms($urandom_range(0, 1));
            end
        end
        run_phase("framing", 1'b1);

        // Lanes aligned four bits apart.
        pad(0, 8); pad(1, 12);
        coms(5);
        put_word(32'h1122_3344);
        coms(2);
        run_phase("skew", 1'b1);

        // Lane 0 sends 0xFF, then reset lands mid-word.
        pad(0, 8); pad(1, 8);
        coms(5);
        put_byte(0, 8'hFF);
        put_byte(1, 8'h77);
        pad(0, 4); pad(1, 4);
        run_phase("midword", 1'b0);

        // After reset, a word without commas is ignored until resync.
        pad(0, 8); pad(1, 8);
        put_word(32'h5A5A_5A5A);
        pad(0, 8); pad(1, 8);
        coms(5);
        put_word(32'h600D_F00D);
        run_phase("resync", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
